// File: rtl/rmst_read_master.sv
// Avalon-MM pipelined read master: one go/base/length command becomes single-word reads whose
// responses land in a credit-limited FIFO. Define RMST_SHOWAHEAD_EN for a show-ahead FIFO output.
module rmst_read_master #(
  parameter int unsigned XAW = 32,
  parameter int unsigned XDW = 128,
  parameter int unsigned FAW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl_fixed_location,
  input  logic [XAW-1:0]     ctrl_read_base,
  input  logic [XAW-1:0]     ctrl_read_length,
  input  logic               ctrl_go,
  output logic               ctrl_done,
  input  logic               user_read_buffer,
  output logic [XDW-1:0]     user_buffer_data,
  output logic               user_data_available,
  output logic [XAW-1:0]     master_address,
  output logic               master_read,
  output logic [XDW/8-1:0]   master_byteenable,
  input  logic [XDW-1:0]     master_readdata,
  input  logic               master_readdatavalid,
  input  logic               master_waitrequest
);

  localparam int unsigned BPW   = XDW / 8;
  localparam int unsigned LB    = $clog2(BPW);
  localparam int unsigned Depth = 2 ** FAW;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state_q;
  logic [XAW-1:0]   addr_q;
  logic [XAW-1:0]   words_left_q;
  logic             fixed_q;
  logic [FAW:0]     pending_q;
  logic [FAW:0]     used_q;
  logic [FAW-1:0]   wr_ptr_q;
  logic [FAW-1:0]   rd_ptr_q;
  logic [XDW-1:0]   mem_q [Depth];

  logic [XAW-1:0]   cmd_words;
  logic [FAW+1:0]   in_flight;
  logic             accept;
  logic             push;
  logic             pop;

  // Byte length rounded up to whole bus words.
  assign cmd_words = (ctrl_read_length >> LB) + XAW'(|ctrl_read_length[LB-1:0]);

  // Every word in the FIFO or still on the bus holds a slot, so the FIFO can never overflow.
  assign in_flight = {1'b0, used_q} + {1'b0, pending_q};

  assign master_read         = (words_left_q != '0) && (in_flight < (FAW+2)'(Depth));
  assign master_address      = addr_q;
  assign master_byteenable   = '1;
  assign accept              = master_read && !master_waitrequest;
  assign push                = master_readdatavalid && (pending_q != '0);
  assign pop                 = user_read_buffer && (used_q != '0);
  assign user_data_available = (used_q != '0);
  assign ctrl_done           = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      fixed_q      <= 1'b0;
      words_left_q <= '0;
      pending_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_go && (cmd_words != '0)) begin
            state_q      <= StIssue;
            addr_q       <= ctrl_read_base;
            fixed_q      <= ctrl_fixed_location;
            words_left_q <= cmd_words;
          end
        end
        StIssue: begin
          if (accept) begin
            words_left_q <= words_left_q - XAW'(1);
            if (!fixed_q) begin
              addr_q <= addr_q + XAW'(BPW);
            end
            if (words_left_q == XAW'(1)) begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          // No accepts happen here, so the last outstanding response empties pending.
          if (push && (pending_q == (FAW+1)'(1))) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (accept && !push) begin
        pending_q <= pending_q + (FAW+1)'(1);
      end else if (!accept && push) begin
        pending_q <= pending_q - (FAW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= master_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FAW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FAW'(1);
      end
      if (push && !pop) begin
        used_q <= used_q + (FAW+1)'(1);
      end else if (pop && !push) begin
        used_q <= used_q - (FAW+1)'(1);
      end
    end
  end

`ifdef RMST_SHOWAHEAD_EN
  assign user_buffer_data = user_data_available ? mem_q[rd_ptr_q] : '0;
`else
  logic [XDW-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (pop) begin
      dout_q <= mem_q[rd_ptr_q];
    end
  end

  assign user_buffer_data = dout_q;
`endif

endmodule

// File: tb/tb_rmst_read_master.sv
// Randomised bench for rmst_read_master: a bus slave with in-order responses plus a queue-based
// model of command progress, issue credit and FIFO contents checked every cycle.
module tb_rmst_read_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctrl_fixed_location;
  logic [31:0]  ctrl_read_base;
  logic [31:0]  ctrl_read_length;
  logic         ctrl_go;
  logic         ctrl_done;
  logic         user_read_buffer;
  logic [127:0] user_buffer_data;
  logic         user_data_available;
  logic [31:0]  master_address;
  logic         master_read;
  logic [15:0]  master_byteenable;
  logic [127:0] master_readdata;
  logic         master_readdatavalid;
  logic         master_waitrequest;

  always #5 clk = ~clk;

  rmst_read_master #(.XAW(32), .XDW(128), .FAW(5)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ctrl_fixed_location  (ctrl_fixed_location),
    .ctrl_read_base       (ctrl_read_base),
    .ctrl_read_length     (ctrl_read_length),
    .ctrl_go              (ctrl_go),
    .ctrl_done            (ctrl_done),
    .user_read_buffer     (user_read_buffer),
    .user_buffer_data     (user_buffer_data),
    .user_data_available  (user_data_available),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_byteenable    (master_byteenable),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest)
  );

  typedef struct {
    logic [127:0] d;
    int           due;
  } rsp_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Slave behaviour knobs.
  int   wr_mode = 0;
  int   lat_min = 3;
  int   lat_max = 3;
  logic force_wait = 1'b0;
  int   epoch = 0;
  int   seq = 0;
  rsp_t rsp_q[$];
  int   last_due = -1;

  // Observations of the bus.
  int          n_reads = 0;
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  int          last_valid_cyc = -1;
  int          done_rise_cyc = -1;
  int          done_low_cnt = 0;
  logic        prev_done = 1'b1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  // Behavioural model.
  logic         m_done = 1'b1;
  int unsigned  m_left = 0;
  logic [31:0]  m_addr = '0;
  logic         m_fix = 1'b0;
  int           m_pend = 0;
  logic [127:0] m_fifo[$];
  logic [127:0] m_dout = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [127:0] mk_data(input logic [31:0] a, input int s);
    logic [15:0] s16;
    logic [31:0] e32;
    s16 = s[15:0];
    e32 = epoch[31:0];
    return {e32, a, 16'h5A5A, s16, ~a};
  endfunction

  task automatic tick(input logic r, input logic g, input logic [31:0] b, input logic [31:0] l,
                      input logic f, input logic p);
    logic         mr;
    logic         acc_m;
    logic [127:0] exp_data;
    int unsigned  words;
    int           lat;
    rsp_t         rs;
    @(negedge clk);
    // Compare outputs for this cycle against the model.
    mr = (m_left != 0) && ((m_fifo.size() + m_pend) < 32);
`ifdef RMST_SHOWAHEAD_EN
    exp_data = (m_fifo.size() != 0) ? m_fifo[0] : '0;
`else
    exp_data = m_dout;
`endif
    chk("ctrl_done", 128'(ctrl_done), 128'(m_done));
    chk("master_read", 128'(master_read), 128'(mr));
    if (mr) chk("master_address", 128'(master_address), 128'(m_addr));
    chk("byteenable", 128'(master_byteenable), 128'(16'hFFFF));
    chk("data_available", 128'(user_data_available), 128'(m_fifo.size() != 0));
    chk("buffer_data", user_buffer_data, exp_data);
    if (prev_stall) begin
      chk("hold_read", 128'(master_read), 128'(1'b1));
      chk("hold_addr", 128'(master_address), 128'(prev_addr));
    end
    if (ctrl_done && !prev_done) done_rise_cyc = cyc;
    if (!ctrl_done) done_low_cnt++;
    prev_done = ctrl_done;

    // Drive inputs.
    rst = r;
    ctrl_go = g;
    ctrl_read_base = b;
    ctrl_read_length = l;
    ctrl_fixed_location = f;
    user_read_buffer = p;
    if (force_wait) master_waitrequest = 1'b1;
    else if (wr_mode == 1) master_waitrequest = ((cyc % 2) == 1);
    else if (wr_mode == 2) master_waitrequest = ($urandom_range(0, 2) == 0);
    else master_waitrequest = 1'b0;
    if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      master_readdatavalid = 1'b1;
      master_readdata = rsp_q[0].d;
      void'(rsp_q.pop_front());
      last_valid_cyc = cyc;
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    // Bus slave: accept and schedule an in-order response.
    prev_stall = master_read && master_waitrequest && !r;
    prev_addr = master_address;
    if (master_read && !master_waitrequest) begin
      n_reads++;
      acc_addr.push_back(master_address);
      acc_cyc.push_back(cyc);
      lat = $urandom_range(lat_min, lat_max);
      rs.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      rs.d = mk_data(master_address, seq);
      last_due = rs.due;
      rsp_q.push_back(rs);
      seq++;
    end

    // Model next state.
    acc_m = mr && !master_waitrequest;
    if (r) begin
      m_done = 1'b1;
      m_left = 0;
      m_pend = 0;
      m_fifo.delete();
      m_dout = '0;
    end else begin
      if (p && m_fifo.size() != 0) m_dout = m_fifo.pop_front();
      if (master_readdatavalid && m_pend != 0) begin
        m_fifo.push_back(master_readdata);
        m_pend--;
      end
      if (acc_m) begin
        m_left--;
        m_pend++;
        if (!m_fix) m_addr = m_addr + 32'd16;
      end
      if (g && m_done) begin
        words = (l >> 4) + ((l[3:0] != 4'd0) ? 1 : 0);
        if (words != 0) begin
          m_left = words;
          m_addr = b;
          m_fix = f;
          m_done = 1'b0;
        end
      end else if (!m_done && m_left == 0 && m_pend == 0) begin
        m_done = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic p);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, 1'b0, p);
  endtask

  task automatic clr();
    acc_addr.delete();
    acc_cyc.delete();
    n_reads = 0;
    seq = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(ctrl_done && !user_data_available && rsp_q.size() == 0) && n < 600) begin
      tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_bound", 128'(n < 600), 128'(1'b1));
  endtask

  task automatic basic_run(input int ep);
    int go_cyc;
    logic [127:0] w0;
    clr();
    epoch = ep;
    wr_mode = 0;
    lat_min = 3;
    lat_max = 3;
    w0 = {ep[31:0], 32'h0000_1000, 16'h5A5A, 16'h0000, 32'hFFFF_EFFF};
    go_cyc = cyc;
    tick(1'b0, 1'b1, 32'h1000, 32'd64, 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("basic_nreads", 128'(n_reads), 128'(4));
    for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
      chk("basic_addr", 128'(acc_addr[i]), 128'(32'h1000 + 32'(16 * i)));
      chk("basic_acc_cycle", 128'(acc_cyc[i]), 128'(go_cyc + 1 + i));
    end
    chk("basic_done_latency", 128'(done_rise_cyc - last_valid_cyc), 128'(1));
`ifdef RMST_SHOWAHEAD_EN
    chk("basic_first_word", user_buffer_data, w0);
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
`else
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("basic_first_word", user_buffer_data, w0);
`endif
    idle(3, 1'b1);
    chk("basic_empty", 128'(user_data_available), 128'(1'b0));
    idle(2, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    logic [127:0] w0;
    logic [127:0] w1;
    rst = 1'b1;
    ctrl_go = 1'b0;
    ctrl_read_base = '0;
    ctrl_read_length = '0;
    ctrl_fixed_location = 1'b0;
    user_read_buffer = 1'b0;
    master_readdata = '0;
    master_readdatavalid = 1'b0;
    master_waitrequest = 1'b0;

    // Reset state.
    tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_done", 128'(ctrl_done), 128'(1'b1));
    chk("rst_read", 128'(master_read), 128'(1'b0));
    chk("rst_addr", 128'(master_address), 128'(32'h0));
    chk("rst_avail", 128'(user_data_available), 128'(1'b0));
    chk("rst_data", user_buffer_data, 128'(0));
    idle(2, 1'b0);

    basic_run(1);

    // Length rounding and zero length.
    clr();
    epoch = 2;
    tick(1'b0, 1'b1, 32'h1100, 32'd20, 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("round_nreads", 128'(n_reads), 128'(2));
    drain();
    clr();
    done_low_cnt = 0;
    tick(1'b0, 1'b1, 32'h1200, 32'd0, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("zero_nreads", 128'(n_reads), 128'(0));
    chk("zero_done_low", 128'(done_low_cnt), 128'(0));

    // Backpressure and credit.
    clr();
    wr_mode = 1;
    lat_min = 1;
    lat_max = 4;
    tick(1'b0, 1'b1, 32'h8000, 32'h400, 1'b0, 1'b0);
    idle(100, 1'b0);
    chk("credit_nreads", 128'(n_reads), 128'(32));
    chk("credit_read_low", 128'(master_read), 128'(1'b0));
    idle(5, 1'b1);
    idle(30, 1'b0);
    chk("credit_release", 128'(n_reads), 128'(37));
    drain();

    // Fixed location.
    clr();
    wr_mode = 2;
    tick(1'b0, 1'b1, 32'h2000, 32'd48, 1'b1, 1'b0);
    idle(20, 1'b0);
    chk("fixed_nreads", 128'(n_reads), 128'(3));
    for (int i = 0; i < acc_addr.size(); i++) chk("fixed_addr", 128'(acc_addr[i]), 128'(32'h2000));
    drain();

    // Push and pop in the same cycle with one word buffered.
    clr();
    epoch = 3;
    wr_mode = 0;
    lat_min = 3;
    lat_max = 3;
    w0 = {32'd3, 32'h0000_3000, 16'h5A5A, 16'h0000, 32'hFFFF_CFFF};
    w1 = {32'd3, 32'h0000_3010, 16'h5A5A, 16'h0001, 32'hFFFF_CFEF};
    tick(1'b0, 1'b1, 32'h3000, 32'd32, 1'b0, 1'b0);
    pc = -1;
    for (int i = 0; i < 20 && pc < 0; i++) begin
      if (user_data_available) begin
        pc = cyc;
        tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      end else begin
        tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      end
    end
    chk("pushpop_same_cycle", 128'(last_valid_cyc), 128'(pc));
    chk("pushpop_avail", 128'(user_data_available), 128'(1'b1));
`ifdef RMST_SHOWAHEAD_EN
    chk("pushpop_word", user_buffer_data, w1);
`else
    chk("pushpop_word", user_buffer_data, w0);
`endif
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("pushpop_empty", 128'(user_data_available), 128'(1'b0));
`ifndef RMST_SHOWAHEAD_EN
    chk("pushpop_word2", user_buffer_data, w1);
`endif
    idle(3, 1'b0);

    // ctrl_go during ISSUE is ignored.
    clr();
    wr_mode = 1;
    tick(1'b0, 1'b1, 32'h4000, 32'd64, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 32'h5000, 32'h400, 1'b0, 1'b0);
    idle(30, 1'b0);
    chk("go_ignored_nreads", 128'(n_reads), 128'(4));
    for (int i = 0; i < acc_addr.size(); i++)
      chk("go_ignored_addr", 128'(acc_addr[i]), 128'(32'h4000 + 32'(16 * i)));
    drain();

    // Reset mid-transfer with responses still on the bus.
    clr();
    wr_mode = 0;
    lat_min = 2;
    lat_max = 2;
    tick(1'b0, 1'b1, 32'h6000, 32'd128, 1'b0, 1'b0);
    for (int i = 0; i < 20 && n_reads < 3; i++) idle(1, 1'b0);
    chk("rstmid_nreads", 128'(n_reads), 128'(3));
    chk("rstmid_pre_avail", 128'(user_data_available), 128'(1'b1));
    force_wait = 1'b1;
    tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    force_wait = 1'b0;
    idle(6, 1'b0);
    chk("rstmid_avail", 128'(user_data_available), 128'(1'b0));
    chk("rstmid_done", 128'(ctrl_done), 128'(1'b1));
    chk("rstmid_no_more_reads", 128'(n_reads), 128'(3));
    basic_run(4);

    // Random traffic.
    wr_mode = 2;
    lat_min = 1;
    lat_max = 6;
    epoch = 5;
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        g;
      logic [31:0] b;
      logic [31:0] l;
      r = ($urandom_range(0, 199) == 0);
      g = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFC0 : ($urandom() & 32'hFFFF_FFF0);
      l = 32'($urandom_range(0, 200));
      tick(r, g, b, l, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
